// File: rtl/pma_cfg_ctrl.sv
// Indirect PMA analog register sequencer for the reconfig controller mgmt port.
// Optional PMA_CFG_AUTO_INIT_EN: one internal write of INIT_DATA after reset.
module pma_cfg_ctrl #(
    parameter int unsigned LCH         = 0,
    parameter int unsigned POLL_LIMIT  = 1023,
    parameter logic [5:0]  INIT_OFFSET = 6'h00,
    parameter logic [31:0] INIT_DATA   = 32'h0000_0020
) (
    input  logic        stable_clk_i,
    input  logic        stable_reset_i,
    input  logic        cmd_req_i,
    input  logic        cmd_wr_i,
    input  logic [5:0]  cmd_offset_i,
    input  logic [31:0] cmd_data_i,
    output logic        cmd_ack_o,
    output logic [31:0] cmd_rdata_o,
    output logic        cmd_err_o,
    output logic        idle_o,
    input  logic        reconfig_busy_i,
    output logic [6:0]  mgmt_address_o,
    output logic        mgmt_read_o,
    output logic        mgmt_write_o,
    output logic [31:0] mgmt_writedata_o,
    input  logic [31:0] mgmt_readdata_i,
    input  logic        mgmt_waitrequest_i
);

    localparam int CLOG = $clog2(POLL_LIMIT + 1);
    localparam int CW   = (CLOG > 10) ? CLOG : 10;

    localparam logic [CW-1:0] LIMIT_M1 = CW'(POLL_LIMIT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    localparam logic [6:0] A_LCH  = 7'h08;
    localparam logic [6:0] A_CTRL = 7'h0A;
    localparam logic [6:0] A_OFS  = 7'h0B;
    localparam logic [6:0] A_DATA = 7'h0C;

    typedef enum logic [3:0] {
        IDLE,
        WR_LCH,
        WR_OFS,
        WR_DATA,
        WR_CTRL,
        POLL,
        RD_DATA,
        DONE,
        INIT_WAIT
    } state_t;

`ifdef PMA_CFG_AUTO_INIT_EN
    localparam state_t RST_STATE = INIT_WAIT;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t        state;
    logic          c_wr;
    logic [5:0]    c_ofs;
    logic [31:0]   c_data;
    logic          c_init;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic [CW-1:0] poll_cnt;

    assign idle_o = (state == IDLE) & ~reconfig_busy_i;

    always_ff @(posedge stable_clk_i or posedge stable_reset_i) begin
        if (stable_reset_i) begin
            state            <= RST_STATE;
            c_wr             <= 1'b0;
            c_ofs            <= '0;
            c_data           <= '0;
            c_init           <= 1'b0;
            err_q            <= 1'b0;
            rdata_q          <= '0;
            poll_cnt         <= '0;
            cmd_ack_o        <= 1'b0;
            cmd_rdata_o      <= '0;
            cmd_err_o        <= 1'b0;
            mgmt_address_o   <= '0;
            mgmt_read_o      <= 1'b0;
            mgmt_write_o     <= 1'b0;
            mgmt_writedata_o <= '0;
        end else begin
            cmd_ack_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_req_i && !reconfig_busy_i) begin
                        c_wr     <= cmd_wr_i;
                        c_ofs    <= cmd_offset_i;
                        c_data   <= cmd_data_i;
                        c_init   <= 1'b0;
                        err_q    <= 1'b0;
                        poll_cnt <= '0;
                        state    <= WR_LCH;
                    end
                end
                INIT_WAIT: begin
                    if (!reconfig_busy_i) begin
                        c_wr     <= 1'b1;
                        c_ofs    <= INIT_OFFSET;
                        c_data   <= INIT_DATA;
                        c_init   <= 1'b1;
                        err_q    <= 1'b0;
                        poll_cnt <= '0;
                        state    <= WR_LCH;
                    end
                end
                // Each transfer: issue cycle, then hold until waitrequest drops.
                WR_LCH: begin
                    if (!mgmt_write_o) begin
                        mgmt_address_o   <= A_LCH;
                        mgmt_writedata_o <= 32'(LCH);
                        mgmt_write_o     <= 1'b1;
                    end else if (!mgmt_waitrequest_i) begin
                        mgmt_write_o <= 1'b0;
                        state        <= WR_OFS;
                    end
                end
                WR_OFS: begin
                    if (!mgmt_write_o) begin
                        mgmt_address_o   <= A_OFS;
                        mgmt_writedata_o <= {26'b0, c_ofs};
                        mgmt_write_o     <= 1'b1;
                    end else if (!mgmt_waitrequest_i) begin
                        mgmt_write_o <= 1'b0;
                        state        <= c_wr ? WR_DATA : WR_CTRL;
                    end
                end
                WR_DATA: begin
                    if (!mgmt_write_o) begin
                        mgmt_address_o   <= A_DATA;
                        mgmt_writedata_o <= c_data;
                        mgmt_write_o     <= 1'b1;
                    end else if (!mgmt_waitrequest_i) begin
                        mgmt_write_o <= 1'b0;
                        state        <= WR_CTRL;
                    end
                end
                WR_CTRL: begin
                    if (!mgmt_write_o) begin
                        mgmt_address_o   <= A_CTRL;
                        mgmt_writedata_o <= c_wr ? 32'h1 : 32'h2;
                        mgmt_write_o     <= 1'b1;
                    end else if (!mgmt_waitrequest_i) begin
                        mgmt_write_o <= 1'b0;
                        state        <= POLL;
                    end
                end
                POLL: begin
                    if (!mgmt_read_o) begin
                        mgmt_address_o <= A_CTRL;
                        mgmt_read_o    <= 1'b1;
                    end else if (!mgmt_waitrequest_i) begin
                        mgmt_read_o <= 1'b0;
                        if (mgmt_readdata_i[8]) begin
                            if (poll_cnt >= LIMIT_M1) begin
                                err_q <= 1'b1;
                                state <= DONE;
                            end else if (poll_cnt != CNT_MAX) begin
                                poll_cnt <= poll_cnt + 1'b1;
                            end
                        end else if (mgmt_readdata_i[9]) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= c_wr ? DONE : RD_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (!mgmt_read_o) begin
                        mgmt_address_o <= A_DATA;
                        mgmt_read_o    <= 1'b1;
                    end else if (!mgmt_waitrequest_i) begin
                        mgmt_read_o <= 1'b0;
                        rdata_q     <= mgmt_readdata_i;
                        state       <= DONE;
                    end
                end
                // Init errors stick on cmd_err_o until the first user ack.
                DONE: begin
                    state <= IDLE;
                    if (c_init) begin
                        if (err_q) cmd_err_o <= 1'b1;
                    end else begin
                        cmd_ack_o   <= 1'b1;
                        cmd_err_o   <= err_q;
                        cmd_rdata_o <= rdata_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pma_cfg_ctrl.sv
// Randomized bench for pma_cfg_ctrl with a transfer-list reference model
// and a stalling Avalon slave; also builds with PMA_CFG_AUTO_INIT_EN.
module tb_pma_cfg_ctrl;

    localparam int          PL    = 4;
    localparam int          LCH_V = 2;
    localparam logic [5:0]  IOFS  = 6'h11;
    localparam logic [31:0] IDAT  = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_req_i = 1'b0;
    logic        cmd_wr_i = 1'b0;
    logic [5:0]  cmd_offset_i = '0;
    logic [31:0] cmd_data_i = '0;
    logic        cmd_ack_o;
    logic [31:0] cmd_rdata_o;
    logic        cmd_err_o;
    logic        idle_o;
    logic        reconfig_busy_i = 1'b0;
    logic [6:0]  mgmt_address_o;
    logic        mgmt_read_o;
    logic        mgmt_write_o;
    logic [31:0] mgmt_writedata_o;
    logic [31:0] mgmt_readdata_i = '0;
    logic        waitreq = 1'b0;

    always #5 clk = ~clk;

    pma_cfg_ctrl #(
        .LCH(LCH_V),
        .POLL_LIMIT(PL),
        .INIT_OFFSET(IOFS),
        .INIT_DATA(IDAT)
    ) dut (
        .stable_clk_i(clk),
        .stable_reset_i(rst),
        .cmd_req_i(cmd_req_i),
        .cmd_wr_i(cmd_wr_i),
        .cmd_offset_i(cmd_offset_i),
        .cmd_data_i(cmd_data_i),
        .cmd_ack_o(cmd_ack_o),
        .cmd_rdata_o(cmd_rdata_o),
        .cmd_err_o(cmd_err_o),
        .idle_o(idle_o),
        .reconfig_busy_i(reconfig_busy_i),
        .mgmt_address_o(mgmt_address_o),
        .mgmt_read_o(mgmt_read_o),
        .mgmt_write_o(mgmt_write_o),
        .mgmt_writedata_o(mgmt_writedata_o),
        .mgmt_readdata_i(mgmt_readdata_i),
        .mgmt_waitrequest_i(waitreq)
    );

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    // slave configuration for the current command
    int          cfg_busy = 0;
    bit          cfg_perr = 0;
    logic [31:0] cfg_rdval = '0;
    int          max_stall = 0;
    bit          idle_noise = 0;
    int          polls_done = 0;
    int          rd0c_seen = 0;

    // reference model state
    bit          m_busy = 0;
    bit          m_init = 0;
    int          cyc = 0;
    int          cap_cyc = 0;
    bit          m_exp_err = 0;
    logic [31:0] m_exp_rdata = '0;
    bit          m_prev_err = 0;
    logic [31:0] m_prev_rdata = '0;
    int          last_lat = 0;
    int          last_polls = 0;
    int          last_rd0c = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic we, input logic [6:0] a,
                                 input logic [31:0] d);
        xfer_t x;
        x.we = we;
        x.addr = a;
        x.data = d;
        return x;
    endfunction

    // Expected bus traffic and result of one command, from the command rules.
    task automatic push_cmd(input bit wr, input logic [5:0] ofs,
                            input logic [31:0] d, input int nb,
                            input bit pe, input logic [31:0] rv);
        int n;
        bit e;
        exp_q.push_back(mk(1'b1, 7'h08, 32'(LCH_V)));
        exp_q.push_back(mk(1'b1, 7'h0B, {26'b0, ofs}));
        if (wr) exp_q.push_back(mk(1'b1, 7'h0C, d));
        exp_q.push_back(mk(1'b1, 7'h0A, wr ? 32'h1 : 32'h2));
        if (nb >= PL) begin
            n = PL;
            e = 1'b1;
        end else begin
            n = nb + 1;
            e = pe;
        end
        for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 7'h0A, '0));
        if (!wr && !e) exp_q.push_back(mk(1'b0, 7'h0C, '0));
        m_exp_err = e;
        m_exp_rdata = (!wr && !e) ? rv : m_prev_rdata;
        polls_done = 0;
        rd0c_seen = 0;
    endtask

    function automatic logic [31:0] resp(input logic [6:0] a);
        logic [31:0] v;
        bit b;
        v = $urandom;
        v[9:8] = 2'b00;
        if (a == 7'h0A) begin
            b = polls_done < cfg_busy;
            v[8] = b;
            v[9] = !b && cfg_perr;
        end else if (a == 7'h0C) begin
            v = cfg_rdval;
        end
        return v;
    endfunction

    task automatic after_reset();
        exp_q.delete();
        m_busy = 0;
        m_init = 0;
        m_prev_rdata = '0;
        m_prev_err = 0;
        cfg_busy = 0;
        cfg_perr = 0;
        polls_done = 0;
`ifdef PMA_CFG_AUTO_INIT_EN
        m_busy = 1;
        m_init = 1;
        push_cmd(1'b1, IOFS, IDAT, 0, 1'b0, '0);
`endif
    endtask

    // model: command capture
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && !m_busy && cmd_req_i && !reconfig_busy_i) begin
                m_busy = 1;
                cap_cyc = cyc;
                push_cmd(cmd_wr_i, cmd_offset_i, cmd_data_i,
                         cfg_busy, cfg_perr, cfg_rdval);
            end
        end
    end

    // Avalon slave with random stalls
    initial begin
        bit in_xfer;
        int stall_left;
        in_xfer = 0;
        stall_left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_xfer = 0;
                waitreq = 1'b0;
            end else if (mgmt_read_o || mgmt_write_o) begin
                if (!in_xfer) begin
                    in_xfer = 1;
                    stall_left = int'($urandom_range(0, max_stall));
                end
                if (stall_left > 0) begin
                    stall_left--;
                    waitreq = 1'b1;
                    mgmt_readdata_i = $urandom;
                end else begin
                    waitreq = 1'b0;
                    mgmt_readdata_i = resp(mgmt_address_o);
                end
            end else begin
                in_xfer = 0;
                waitreq = idle_noise ? 1'($urandom) : 1'b0;
                mgmt_readdata_i = $urandom;
            end
        end
    end

    // compare process
    initial begin
        bit prev_stall;
        logic [40:0] snap;
        prev_stall = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall)
                chk("stall_hold", {mgmt_read_o, mgmt_write_o,
                    mgmt_address_o, mgmt_writedata_o}, snap);
            chk("rd_wr_excl", mgmt_read_o & mgmt_write_o, 0);
            if ((mgmt_read_o || mgmt_write_o) && !waitreq) begin
                chk("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    chk("xfer_we", mgmt_write_o, e.we);
                    chk("xfer_addr", mgmt_address_o, e.addr);
                    if (e.we) chk("xfer_wdata", mgmt_writedata_o, e.data);
                end
                if (mgmt_read_o && mgmt_address_o == 7'h0A) polls_done++;
                if (mgmt_read_o && mgmt_address_o == 7'h0C) rd0c_seen++;
            end
            prev_stall = (mgmt_read_o || mgmt_write_o) && waitreq;
            snap = {mgmt_read_o, mgmt_write_o, mgmt_address_o, mgmt_writedata_o};
            if (m_init && exp_q.size() == 0 && idle_o) begin
                m_init = 0;
                m_busy = 0;
            end
            if (!cmd_ack_o) begin
                chk("rdata_hold", cmd_rdata_o, m_prev_rdata);
                chk("err_hold", cmd_err_o, m_prev_err);
            end else begin
                chk("ack_expected", m_busy && !m_init && exp_q.size() == 0, 1);
                chk("ack_err", cmd_err_o, m_exp_err);
                chk("ack_rdata", cmd_rdata_o, m_exp_rdata);
                m_prev_rdata = m_exp_rdata;
                m_prev_err = m_exp_err;
                m_busy = 0;
                last_lat = cyc - cap_cyc;
                last_polls = polls_done;
                last_rd0c = rd0c_seen;
            end
            if (!m_init) chk("idle", idle_o, !m_busy && !reconfig_busy_i);
        end
    end

    task automatic wait_ack();
        bit got;
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (cmd_ack_o) got = 1;
        end
        #1 cmd_req_i = 1'b0;
        chk("ack_seen", got, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (idle_o && !m_init) break;
        end
        #1;
        chk("wait_idle", idle_o, 1);
    endtask

    task automatic do_cmd(input bit wr, input logic [5:0] ofs,
                          input logic [31:0] d, input int nb, input bit pe,
                          input logic [31:0] rv, input int ms);
        @(posedge clk);
        #1;
        cfg_busy = nb;
        cfg_perr = pe;
        cfg_rdval = rv;
        max_stall = ms;
        cmd_wr_i = wr;
        cmd_offset_i = ofs;
        cmd_data_i = d;
        cmd_req_i = 1'b1;
        @(posedge clk);
        #1;
        cmd_wr_i = 1'($urandom);
        cmd_offset_i = 6'($urandom);
        cmd_data_i = $urandom;
        wait_ack();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        after_reset();
        #2;
        chk("rst_ack", cmd_ack_o, 0);
        chk("rst_rdata", cmd_rdata_o, 0);
        chk("rst_err", cmd_err_o, 0);
        chk("rst_strobes", {mgmt_read_o, mgmt_write_o}, 0);
        chk("rst_addr", mgmt_address_o, 0);
        chk("rst_wdata", mgmt_writedata_o, 0);
`ifdef PMA_CFG_AUTO_INIT_EN
        chk("rst_idle", idle_o, 0);
`else
        chk("rst_idle", idle_o, 1);
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();

        // minimum-latency write
        do_cmd(1'b1, 6'h05, 32'h1A, 0, 1'b0, '0, 0);
        chk("t1_latency", last_lat, 11);
        chk("t1_err", cmd_err_o, 0);
        chk("t1_polls", last_polls, 1);

        // read with three busy polls
        do_cmd(1'b0, 6'h03, $urandom, 3, 1'b0, 32'h2B, 0);
        chk("t2_rdata", cmd_rdata_o, 32'h2B);
        chk("t2_polls", last_polls, 4);
        chk("t2_rd0c", last_rd0c, 1);
        chk("t2_err", cmd_err_o, 0);

        // busy stuck: poll limit abort
        do_cmd(1'b1, 6'h21, $urandom, 50, 1'b0, '0, 2);
        chk("t3_polls", last_polls, 4);
        chk("t3_err", cmd_err_o, 1);

        // error bit on final poll of a read
        do_cmd(1'b0, 6'h07, $urandom, 1, 1'b1, 32'hDEAD, 3);
        chk("t4_err", cmd_err_o, 1);
        chk("t4_rd0c", last_rd0c, 0);
        chk("t4_rdata", cmd_rdata_o, 32'h2B);
        chk("t4_polls", last_polls, 2);

        // request held off by reconfig busy
        @(posedge clk);
        #1;
        cfg_busy = 0;
        cfg_perr = 0;
        max_stall = 0;
        reconfig_busy_i = 1'b1;
        cmd_wr_i = 1'b1;
        cmd_offset_i = 6'h09;
        cmd_data_i = 32'hC0FFEE;
        cmd_req_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_strobe", mgmt_read_o | mgmt_write_o, 0);
        end
        @(posedge clk);
        #1 reconfig_busy_i = 1'b0;
        wait_ack();
        chk("t5_latency", last_lat, 11);

        // random traffic with stalls
        idle_noise = 1;
        for (int k = 0; k < 40; k++)
            do_cmd(1'($urandom), 6'($urandom), $urandom,
                   int'($urandom_range(0, 5)), ($urandom % 6) == 0,
                   $urandom, int'($urandom_range(0, 5)));

        // reset during the data write
        @(posedge clk);
        #1;
        cfg_busy = 0;
        cfg_perr = 0;
        max_stall = 3;
        cmd_wr_i = 1'b1;
        cmd_offset_i = 6'h2A;
        cmd_data_i = 32'h55AA;
        cmd_req_i = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mgmt_write_o && mgmt_address_o == 7'h0C) found = 1;
        end
        chk("t7_reach_wrdata", found, 1);
        #1 rst = 1'b1;
        #1;
        chk("t7_wr_drop", mgmt_write_o, 0);
        chk("t7_rd_drop", mgmt_read_o, 0);
        chk("t7_no_ack", cmd_ack_o, 0);
        cmd_req_i = 1'b0;
        after_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();

        for (int k = 0; k < 8; k++)
            do_cmd(1'($urandom), 6'($urandom), $urandom,
                   int'($urandom_range(0, 4)), ($urandom % 4) == 0,
                   $urandom, int'($urandom_range(0, 5)));

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
